// File: rtl/silly_function.sv
// Three-input Boolean leaf y = ~b & (~c | a) with a registered self-check stage
// that compares y against a supplied expectation and keeps saturating counters.
module silly_function #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    input  logic             in_valid,
    input  logic             y_exp,
    output logic             y_q,
    output logic             out_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic miss_c;

    // Zero-latency function output, live regardless of clock or reset.
    assign y = ~b & (~c | a);

    // Case inequality so an X/Z expectation is flagged as a mismatch.
    assign miss_c = (y !== y_exp);

    // Observation registers; counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q       <= 1'b0;
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
        end else if (in_valid) begin
            y_q       <= y;
            out_valid <= 1'b1;
            mismatch  <= miss_c;
            if (vec_count != CNT_MAX) begin
                vec_count <= vec_count + CNT_W'(1);
            end
            if (miss_c && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end else begin
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_silly_function.sv
// Directed self-checking bench for silly_function: truth table, reset behaviour,
// accepted-vector checking, mismatch counting and counter saturation.
module tb_silly_function;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic        a, b, c;
    logic        in_valid;
    logic        in_valid_s;
    logic        y_exp;

    logic        y, y_q, out_valid, mismatch;
    logic [31:0] err_count, vec_count;

    logic        y_s, y_q_s, out_valid_s, mismatch_s;
    logic [1:0]  err_count_s, vec_count_s;

    int total;
    int bad;

    // Expected y indexed by {a,b,c}: 000->1 ... 111->0.
    logic [7:0] tab;

    silly_function #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .y(y),
        .in_valid(in_valid), .y_exp(y_exp), .y_q(y_q), .out_valid(out_valid),
        .mismatch(mismatch), .err_count(err_count), .vec_count(vec_count)
    );

    silly_function #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .y(y_s),
        .in_valid(in_valid_s), .y_exp(y_exp), .y_q(y_q_s), .out_valid(out_valid_s),
        .mismatch(mismatch_s), .err_count(err_count_s), .vec_count(vec_count_s)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int idx, input logic exp_v, input logic v);
        logic [2:0] abc;
        abc = 3'(idx);
        {a, b, c} = abc;
        y_exp     = exp_v;
        in_valid  = v;
    endtask

    task automatic test_comb_sweep();
        for (int i = 0; i < 8; i++) begin
            drive(i, 1'b0, 1'b0);
            #1;
            total++;
            if (y !== tab[i]) begin
                bad++;
                $display("FAIL comb_y idx=%0d got=%b want=%b", i, y, tab[i]);
            end
            #1;
        end
        total++;
        if ({y_q, out_valid, mismatch} !== 3'b000 || err_count !== 0 || vec_count !== 0) begin
            bad++;
            $display("FAIL reset_state got y_q=%b ov=%b mm=%b err=%0d vec=%0d want all 0",
                     y_q, out_valid, mismatch, err_count, vec_count);
        end
    endtask

    task automatic test_reset_hold();
        clk_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(i % 8, ~tab[i % 8], 1'b1);
            #1;
            total++;
            if (y !== tab[i % 8]) begin
                bad++;
                $display("FAIL rst_y idx=%0d got=%b want=%b", i % 8, y, tab[i % 8]);
            end
            total++;
            if ({y_q, out_valid, mismatch} !== 3'b000 || err_count !== 0 || vec_count !== 0) begin
                bad++;
                $display("FAIL rst_hold step=%0d got y_q=%b ov=%b err=%0d vec=%0d want 0",
                         i, y_q, out_valid, err_count, vec_count);
            end
            #2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic test_all_vectors();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(i, tab[i], 1'b1);
            @(posedge clk);
            #1;
            total++;
            if (y_q !== tab[i] || out_valid !== 1'b1 || mismatch !== 1'b0) begin
                bad++;
                $display("FAIL vec_out idx=%0d got y_q=%b ov=%b mm=%b want y_q=%b ov=1 mm=0",
                         i, y_q, out_valid, mismatch, tab[i]);
            end
            total++;
            if (vec_count !== 32'(i + 1) || err_count !== 0) begin
                bad++;
                $display("FAIL vec_cnt idx=%0d got vec=%0d err=%0d want vec=%0d err=0",
                         i, vec_count, err_count, i + 1);
            end
        end
    endtask

    task automatic test_mismatch();
        @(negedge clk);
        drive(5, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (mismatch !== 1'b1 || y_q !== 1'b1 || err_count !== 1 || vec_count !== 9) begin
            bad++;
            $display("FAIL mm_101 got mm=%b y_q=%b err=%0d vec=%0d want mm=1 y_q=1 err=1 vec=9",
                     mismatch, y_q, err_count, vec_count);
        end
        @(negedge clk);
        drive(6, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (mismatch !== 1'b1 || y_q !== 1'b0 || err_count !== 2 || vec_count !== 10) begin
            bad++;
            $display("FAIL mm_110 got mm=%b y_q=%b err=%0d vec=%0d want mm=1 y_q=0 err=2 vec=10",
                     mismatch, y_q, err_count, vec_count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mismatch !== 1'b0 || out_valid !== 1'b0 || y_q !== 1'b0 || err_count !== 2 || vec_count !== 10) begin
            bad++;
            $display("FAIL mm_idle got mm=%b ov=%b y_q=%b err=%0d vec=%0d want 0 0 0 2 10",
                     mismatch, out_valid, y_q, err_count, vec_count);
        end
    endtask

    task automatic test_idle_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (err_count !== 0 || vec_count !== 0) begin
            bad++;
            $display("FAIL mid_rst got err=%0d vec=%0d want 0 0", err_count, vec_count);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(i + 2, (i == 1) ? ~tab[i + 2] : tab[i + 2], 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (vec_count !== 3 || err_count !== 1 || out_valid !== 1'b0 || mismatch !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got vec=%0d err=%0d ov=%b mm=%b want 3 1 0 0",
                         k, vec_count, err_count, out_valid, mismatch);
            end
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (vec_count !== 0 || err_count !== 0 || out_valid !== 1'b0 || y_q !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got vec=%0d err=%0d ov=%b y_q=%b want all 0",
                     vec_count, err_count, out_valid, y_q);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_saturate();
        int want;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0);
            in_valid_s = 1'b1;
            @(posedge clk);
            #1;
            want = (k > 3) ? 3 : k;
            total++;
            if (vec_count_s !== 2'(want) || err_count_s !== 2'(want) || mismatch_s !== 1'b1) begin
                bad++;
                $display("FAIL sat k=%0d got vec=%0d err=%0d mm=%b want vec=%0d err=%0d mm=1",
                         k, vec_count_s, err_count_s, mismatch_s, want, want);
            end
        end
        @(negedge clk);
        in_valid_s = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        tab        = 8'b0011_0001;
        clk_en     = 1'b0;
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
        y_exp      = 1'b0;
        {a, b, c}  = 3'b000;
        reset      = 1'b1;
        #1;
        reset      = 1'b0;
        test_comb_sweep();
        test_reset_hold();
        test_all_vectors();
        test_mismatch();
        test_idle_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/silly_function.md
Name: silly_function

Overview:
- Implements the 3-input Boolean function y = ~b & (~c | a), equivalent to (~b & ~c) | (a & ~b), as a purely combinational output.
- Adds a clocked observation and self-check stage. It registers the result, compares it against a supplied expected value, and keeps mismatch and vector counters.
- Used as a small logic leaf and as a self-checking truth-table block in lab-level designs.

Parameters:
- CNT_W, 32, width of the err_count and vec_count counters (min 2).

Ports:
- clk  in  1  single clock, rising-edge active
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- a  in  1  function input, MSB of the {a,b,c} index
- b  in  1  function input
- c  in  1  function input, LSB of the {a,b,c} index
- y  out  1  combinational function output, independent of clk and reset
- in_valid  in  1  qualifies a, b, c and y_exp for the checker on this clock edge
- y_exp  in  1  expected value of y for the current inputs
- y_q  out  1  registered copy of y
- out_valid  out  1  y_q, mismatch and the counters were updated on the last edge
- mismatch  out  1  registered: y differed from y_exp on the last accepted vector
- err_count  out  CNT_W  number of accepted vectors that mismatched
- vec_count  out  CNT_W  number of accepted vectors

Behaviour:
- Truth table for {a,b,c} -> y: 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
- y is purely combinational, with zero latency.
- y is valid at all times, including while reset is asserted.
- y must settle within the same cycle in which the inputs change.
- If any of a, b, c is X or Z, y may be X. There is no X-masking requirement.
- Reset asserted (reset=0): y_q, out_valid, mismatch, err_count and vec_count all go to 0 immediately, without waiting for a clock edge.
- These registers hold 0 while reset stays low.
- Reset deassertion is synchronised by the register logic. The first edge at which a vector can be accepted is the first rising edge after reset goes high.
- On a rising edge with reset=1 and in_valid=1:
  - y_q <= y
  - mismatch <= (y != y_exp)
  - vec_count <= vec_count + 1
  - err_count <= err_count + 1 if y != y_exp
  - out_valid <= 1
- On a rising edge with reset=1 and in_valid=0:
  - out_valid <= 0
  - mismatch <= 0
  - y_q, err_count and vec_count hold their values.
- Latency: 1 cycle from an accepted vector to y_q, mismatch and the counter updates.
- Counters saturate at 2^CNT_W-1 and never wrap. err_count never exceeds vec_count.
- A y_exp of X or Z counts as a mismatch (4-state inequality).
- Reset during operation discards any in-flight result and clears both counters.
- Back-to-back in_valid on consecutive cycles is supported, one vector per cycle.
- There is no backpressure.

Test Plan:
- Sweep {a,b,c} 000..111 with no clock activity -> y = 1,0,0,0,1,1,0,0 in index order, each within the same cycle.
- Hold reset=0 for 2.7 cycles while driving vectors with in_valid=1 -> y_q=0, out_valid=0, err_count=0, vec_count=0; y still follows the truth table.
- After reset release, apply all 8 vectors with the correct y_exp on consecutive cycles -> vec_count=8, err_count=0, mismatch never 1, y_q matches the table with 1-cycle lag.
- Apply {a,b,c}=101 with y_exp=0, then 110 with y_exp=1 -> mismatch=1 on both following edges, err_count=2.
- Accept 3 vectors, drop in_valid for 2 cycles, then assert reset=0 between clock edges -> counters hold 3 during the idle cycles, then clear to 0 immediately on reset assertion, without waiting for an edge.
- With CNT_W=2, accept 5 mismatching vectors -> vec_count and err_count saturate at 3.
